spin_executor: RTL and testbench

//  Executes the in-place spin requested by turn_around_move. Latches the angle (motion_command)
//  and speed (output_speed), drives opposite-signed wheel velocities, and integrates the turned

---
 rtl/spin_executor.sv | 155 +++++++++++++++
 tb/tb_spin_executor.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/spin_executor.sv
//------------------------------------------------------------------------------
// Module      : spin_executor
// Description : Executes an in-place spin: latches angle/speed/direction,
//               drives opposite-signed wheel velocities and integrates the
//               turned angle on a prescaled tick until the target is reached.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module spin_executor #(
   parameter int TICK_DIV   = 4,   // clk cycles per angle-integration tick (>=2)
   parameter int WHEEL_GAIN = 16   // wheel magnitude per unit of speed
) (
   input  logic              clk,
   input  logic              rst,            // asynchronous, active-low
   input  logic              start,
   input  logic              spin_dir,       // 1 = counter-clockwise
   input  logic [9:0]        motion_command, // requested angle in degrees
   input  logic [2:0]        output_speed,   // degrees per tick
   input  logic              abort,
   output logic signed [7:0] left_wheel,
   output logic signed [7:0] right_wheel,
   output logic              busy,
   output logic              done_spin
);

   localparam int            PW        = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
   localparam logic [9:0]    FULL_TURN = 10'd360;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      NORM = 2'd1,
      SPIN = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t        state_q;
   logic [9:0]    target_q;
   logic [2:0]    spd_q;
   logic          dir_q;
   logic [9:0]    acc_q;
   logic [PW-1:0] pre_q;
   logic [7:0]    left_q;
   logic [7:0]    right_q;
   logic          busy_q;
   logic          done_q;

   logic [9:0]    acc_d;
   logic [7:0]    mag_d;
   logic [7:0]    neg_mag_d;

   // Accumulated angle after the next tick; cannot overflow 10 bits (<= 359+7).
   assign acc_d     = acc_q + {7'd0, spd_q};
   // Wheel magnitude and its two's complement for the opposite wheel.
   assign mag_d     = {5'd0, spd_q} * 8'(WHEEL_GAIN);
   assign neg_mag_d = ~mag_d + 8'd1;

   // Spin sequencer: all outputs are registered alongside the state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         target_q <= 10'd0;
         spd_q    <= 3'd0;
         dir_q    <= 1'b0;
         acc_q    <= 10'd0;
         pre_q    <= '0;
         left_q   <= 8'd0;
         right_q  <= 8'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else if (abort && (state_q != IDLE)) begin
         // Abort cancels any spin in progress without issuing a done.
         state_q <= IDLE;
         left_q  <= 8'd0;
         right_q <= 8'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start && !abort) begin
                  target_q <= motion_command;
                  spd_q    <= output_speed;
                  dir_q    <= spin_dir;
                  if (output_speed == 3'd0) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= NORM;
                     busy_q  <= 1'b1;
                  end
               end
            end

            NORM: begin
               // One full-turn subtraction per cycle; at most two are needed.
               if (target_q >= FULL_TURN) begin
                  target_q <= target_q - FULL_TURN;
               end else if (target_q == 10'd0) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  state_q <= SPIN;
                  acc_q   <= 10'd0;
                  pre_q   <= '0;
                  left_q  <= dir_q ? neg_mag_d : mag_d;
                  right_q <= dir_q ? mag_d : neg_mag_d;
               end
            end

            SPIN: begin
               if (pre_q == PRE_LAST) begin
                  // Prescaler wrap is the integration tick.
                  pre_q <= '0;
                  acc_q <= acc_d;
                  if (acc_d >= target_q) begin
                     state_q <= DONE;
                     left_q  <= 8'd0;
                     right_q <= 8'd0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end else begin
                  pre_q <= pre_q + PW'(1);
               end
            end

            DONE: begin
               // Hold done until the requester drops start.
               left_q  <= 8'd0;
               right_q <= 8'd0;
               busy_q  <= 1'b0;
               if (!start) begin
                  state_q <= IDLE;
                  done_q  <= 1'b0;
               end
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign left_wheel  = left_q;
   assign right_wheel = right_q;
   assign busy        = busy_q;
   assign done_spin   = done_q;

endmodule

`default_nettype wire

// File: tb/tb_spin_executor.sv
//------------------------------------------------------------------------------
// Module      : tb_spin_executor
// Description : Self-checking bench for spin_executor with an expected-result
//               queue filled at stimulus time and drained at spin completion.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_spin_executor;

   localparam int TICK_DIV   = 4;
   localparam int WHEEL_GAIN = 16;

   logic              clk;
   logic              rst;
   logic              start;
   logic              spin_dir;
   logic [9:0]        motion_command;
   logic [2:0]        output_speed;
   logic              abort;
   logic signed [7:0] left_wheel;
   logic signed [7:0] right_wheel;
   logic              busy;
   logic              done_spin;

   typedef struct {
      int cycles;
      int left;
      int right;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks;
   int   n_fail;

   spin_executor #(
      .TICK_DIV   (TICK_DIV),
      .WHEEL_GAIN (WHEEL_GAIN)
   ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .spin_dir       (spin_dir),
      .motion_command (motion_command),
      .output_speed   (output_speed),
      .abort          (abort),
      .left_wheel     (left_wheel),
      .right_wheel    (right_wheel),
      .busy           (busy),
      .done_spin      (done_spin)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference model of the spin: duration in wheel-active cycles and wheel values.
   function automatic exp_t model(input int cmd, input int spd, input bit dir);
      exp_t e;
      int   t;
      t = cmd;
      while (t >= 360) t -= 360;
      if (spd == 0 || t == 0) begin
         e.cycles = 0;
         e.left   = 0;
         e.right  = 0;
      end else begin
         e.cycles = ((t + spd - 1) / spd) * TICK_DIV;
         e.left   = dir ? -(spd * WHEEL_GAIN) : (spd * WHEEL_GAIN);
         e.right  = -e.left;
      end
      return e;
   endfunction

   // Full 4-phase spin transaction; optionally rewrites motion_command mid-spin.
   task automatic run_spin(input string tag, input int cmd, input int spd, input bit dir,
                           input int change_at);
      exp_t got;
      exp_t e;
      int   n;
      int   nz;
      bit   fin;
      sb_q.push_back(model(cmd, spd, dir));
      motion_command = 10'(cmd);
      output_speed   = 3'(spd);
      spin_dir       = dir;
      start          = 1'b1;
      n   = 0;
      nz  = 0;
      fin = 1'b0;
      got.cycles = 0;
      got.left   = 0;
      got.right  = 0;
      while (!fin && n < 2000) begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            if (spd == 0) chk({tag, "_done_lat"}, int'(done_spin), 1);
            else          chk({tag, "_busy_lat"}, int'(busy), 1);
         end
         if (n == change_at) motion_command = 10'd500;
         if (left_wheel != 8'sd0) begin
            nz++;
            got.left  = int'(left_wheel);
            got.right = int'(right_wheel);
         end
         if (done_spin) fin = 1'b1;
      end
      if (!fin) begin
         chk({tag, "_timeout"}, 1, 0);
         start = 1'b0;
         @(negedge clk);
         void'(sb_q.pop_front());
         return;
      end
      got.cycles = nz;
      e = sb_q.pop_front();
      chk({tag, "_cycles"}, got.cycles, e.cycles);
      chk({tag, "_left"},   got.left,   e.left);
      chk({tag, "_right"},  got.right,  e.right);
      chk({tag, "_wheel_off"}, int'(left_wheel) | int'(right_wheel), 0);
      chk({tag, "_busy_off"}, int'(busy), 0);
      repeat (2) @(negedge clk);
      chk({tag, "_done_hold"}, int'(done_spin), 1);
      start = 1'b0;
      @(negedge clk);
      chk({tag, "_done_clr"}, int'(done_spin), 0);
      @(negedge clk);
   endtask

   initial begin
      int dcount;
      n_checks       = 0;
      n_fail         = 0;
      rst            = 1'b0;
      start          = 1'b0;
      spin_dir       = 1'b0;
      motion_command = 10'd0;
      output_speed   = 3'd0;
      abort          = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_left",  int'(left_wheel),  0);
      chk("rst_right", int'(right_wheel), 0);
      chk("rst_busy",  int'(busy),        0);
      chk("rst_done",  int'(done_spin),   0);
      rst = 1'b1;
      @(negedge clk);

      run_spin("t1",  90,  3, 1'b1, 0);
      run_spin("t2",  400, 5, 1'b0, 0);
      run_spin("t3a", 720, 7, 1'b1, 0);
      run_spin("t3b", 100, 0, 1'b1, 0);
      run_spin("t4",  1023, 7, 1'b0, 0);
      run_spin("t5b", 90,  3, 1'b1, 10);

      // Abort at cycle 50 of a spin: back to idle with no done.
      motion_command = 10'd90;
      output_speed   = 3'd3;
      spin_dir       = 1'b1;
      start          = 1'b1;
      repeat (50) @(negedge clk);
      chk("t5_spinning", int'(left_wheel), -48);
      abort = 1'b1;
      start = 1'b0;
      @(negedge clk);
      abort = 1'b0;
      chk("t5_abort_wheel", int'(left_wheel) | int'(right_wheel), 0);
      chk("t5_abort_busy",  int'(busy), 0);
      dcount = 0;
      repeat (10) begin
         @(negedge clk);
         if (done_spin) dcount++;
      end
      chk("t5_no_done", dcount, 0);

      // Abort held in idle blocks acceptance.
      abort = 1'b1;
      start = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_abort_block", int'(busy), 0);
      start = 1'b0;
      abort = 1'b0;
      @(negedge clk);

      // Asynchronous reset mid-spin.
      motion_command = 10'd90;
      output_speed   = 3'd3;
      spin_dir       = 1'b1;
      start          = 1'b1;
      repeat (30) @(negedge clk);
      chk("t6_spinning", int'(right_wheel), 48);
      #2 rst = 1'b0;
      #1;
      chk("t6_async_wheel", int'(left_wheel) | int'(right_wheel), 0);
      chk("t6_async_busy",  int'(busy), 0);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      run_spin("t6", 10, 1, 1'b1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
